// File: rtl/sms_pkg.sv
// Shared encodings and helpers for the SMS SRAM access path.
// Holds access-size codes, the SRAM address width and requester indices.
package sms_pkg;

  localparam int SMS_AW = 17;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam logic PORT_AHB = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Sizes above a word are rejected; halfword/word must be naturally aligned.
  function automatic logic access_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sms_ram_arb_pick.sv
// Combinational 2-way picker: single requester wins outright; on a tie either
// round-robin against the last winner or port 0 unless port 1 has starved.
module sms_ram_arb_pick
  import sms_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic       p0_req_i,
  input  logic       p1_req_i,
  input  logic       rr_mode_i,
  input  logic       last_i,
  input  logic [7:0] wait_cnt_i,
  output logic       vld_o,
  output logic       win_o
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  always_comb begin
    vld_o = p0_req_i | p1_req_i;
    win_o = PORT_AHB;
    if (p0_req_i && p1_req_i) begin
      if (rr_mode_i) begin
        win_o = ~last_i;
      end else if (wait_cnt_i == MAX_W) begin
        win_o = PORT_AUX;
      end
    end else if (p1_req_i) begin
      win_o = PORT_AUX;
    end
  end

endmodule

// File: rtl/sms_ram_arb.sv
// Two-port arbiter for the single-ported SMS SRAM: one grant per cycle, RAM
// command driven straight from the winner, read data routed back one cycle later.
module sms_ram_arb
  import sms_pkg::*;
#(
  parameter int AW       = SMS_AW,
  parameter int MAX_WAIT = 8
) (
  input  logic          i_sys_hclk,
  input  logic          i_sys_rst,
  input  logic          cfg_rr,
  input  logic          p0_req,
  input  logic          p0_write,
  input  logic [2:0]    p0_size,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_write,
  input  logic [2:0]    p1_size,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic          ram_sel,
  output logic          ram_write,
  output logic [2:0]    ram_size,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          ram_idle
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic       rd_own_q, rd_own_d;
  logic       rsp_vld_q, rsp_vld_d;
  logic       err_q, err_d;
  logic       last_q, last_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic          pick_vld, pick_win, win_vld, win_legal;
  logic          w_write;
  logic [2:0]    w_size;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wdata;

  sms_ram_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .p0_req_i   (p0_req),
    .p1_req_i   (p1_req),
    .rr_mode_i  (cfg_rr),
    .last_i     (last_q),
    .wait_cnt_i (wait_cnt_q),
    .vld_o      (pick_vld),
    .win_o      (pick_win)
  );

  // Reset suppresses every grant so nothing is issued or consumed that cycle.
  assign win_vld = pick_vld & ~i_sys_rst;

  always_comb begin
    w_write = p0_write;
    w_size  = p0_size;
    w_addr  = p0_addr;
    w_wdata = p0_wdata;
    if (pick_win == PORT_AUX) begin
      w_write = p1_write;
      w_size  = p1_size;
      w_addr  = p1_addr;
      w_wdata = p1_wdata;
    end
  end

  assign win_legal = access_legal(w_size, w_addr[1:0]);
  assign p0_gnt    = win_vld & (pick_win == PORT_AHB);
  assign p1_gnt    = win_vld & (pick_win == PORT_AUX);

  always_comb begin
    ram_sel   = 1'b0;
    ram_write = 1'b0;
    ram_size  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (win_vld && win_legal) begin
      ram_sel   = 1'b1;
      ram_write = w_write;
      ram_size  = w_size;
      ram_addr  = w_addr;
      ram_wdata = w_wdata;
    end
  end

  always_comb begin
    rsp_vld_d = 1'b0;
    err_d     = 1'b0;
    rd_own_d  = rd_own_q;
    last_d    = last_q;
    if (win_vld) begin
      last_d   = pick_win;
      rd_own_d = pick_win;
      if (!win_legal) begin
        err_d = 1'b1;
      end else if (!w_write) begin
        rsp_vld_d = 1'b1;
      end
    end
    // Starvation counter only matters in fixed-priority mode.
    wait_cnt_d = 8'd0;
    if (!cfg_rr && p1_req && !p1_gnt) begin
      wait_cnt_d = (wait_cnt_q < MAX_W) ? wait_cnt_q + 8'd1 : wait_cnt_q;
    end
  end

  always_ff @(posedge i_sys_hclk) begin
    if (i_sys_rst) begin
      rd_own_q   <= PORT_AHB;
      rsp_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= PORT_AUX;
      wait_cnt_q <= 8'd0;
    end else begin
      rd_own_q   <= rd_own_d;
      rsp_vld_q  <= rsp_vld_d;
      err_q      <= err_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Responses are masked during reset so a pending one is dropped.
  logic rsp_live, own0, own1;
  assign rsp_live = ~i_sys_rst;
  assign own0     = rsp_live & (rd_own_q == PORT_AHB);
  assign own1     = rsp_live & (rd_own_q == PORT_AUX);

  assign p0_rvalid = own0 & (rsp_vld_q | err_q);
  assign p0_err    = own0 & err_q;
  assign p0_rdata  = (own0 & rsp_vld_q) ? ram_rdata : 32'h0;
  assign p1_rvalid = own1 & (rsp_vld_q | err_q);
  assign p1_err    = own1 & err_q;
  assign p1_rdata  = (own1 & rsp_vld_q) ? ram_rdata : 32'h0;

  assign ram_idle = ~p0_req & ~p1_req & ~rsp_vld_q & ~err_q;

endmodule

// File: tb/tb_sms_ram_arb.sv
// Bench for sms_ram_arb: directed scenarios plus randomized traffic checked
// against a cycle-level arbitration/memory model with an expected-response queue.
module tb_sms_ram_arb;
  import sms_pkg::*;

  localparam int AW       = 17;
  localparam int MAX_WAIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_rr;
  logic          rq[2];
  logic          wr[2];
  logic [2:0]    sz[2];
  logic [AW-1:0] ad[2];
  logic [31:0]   wd[2];

  logic          p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          ram_sel, ram_write, ram_idle;
  logic [2:0]    ram_size;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'h0;

  sms_ram_arb #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .i_sys_hclk (clk),
    .i_sys_rst  (rst),
    .cfg_rr     (cfg_rr),
    .p0_req     (rq[0]),
    .p0_write   (wr[0]),
    .p0_size    (sz[0]),
    .p0_addr    (ad[0]),
    .p0_wdata   (wd[0]),
    .p0_gnt     (p0_gnt),
    .p0_rvalid  (p0_rvalid),
    .p0_rdata   (p0_rdata),
    .p0_err     (p0_err),
    .p1_req     (rq[1]),
    .p1_write   (wr[1]),
    .p1_size    (sz[1]),
    .p1_addr    (ad[1]),
    .p1_wdata   (wd[1]),
    .p1_gnt     (p1_gnt),
    .p1_rvalid  (p1_rvalid),
    .p1_rdata   (p1_rdata),
    .p1_err     (p1_err),
    .ram_sel    (ram_sel),
    .ram_write  (ram_write),
    .ram_size   (ram_size),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_idle   (ram_idle)
  );

  // Byte lanes touched by an access (write data is lane-positioned).
  function automatic logic [31:0] lane_mask(input logic [2:0] s, input logic [1:0] a);
    case (s)
      3'd0:    return 32'h0000_00FF << (8 * int'(a));
      3'd1:    return a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // ---------------- SRAM model ----------------
  logic [31:0] ram_mem[0:1023];
  always @(posedge clk) begin
    if (ram_sel) begin
      if (ram_write)
        ram_mem[ram_addr[11:2]] <= (ram_mem[ram_addr[11:2]] & ~lane_mask(ram_size, ram_addr[1:0]))
                                 | (ram_wdata & lane_mask(ram_size, ram_addr[1:0]));
      else
        ram_rdata <= ram_mem[ram_addr[11:2]];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int          n_chk = 0;
  int          n_fail = 0;
  int          m_last, m_wait;
  logic [31:0] ref_mem[0:1023];
  logic [33:0] exp_q[$];   // {err, owner, data}
  int          mode[2];    // 0 none, 1 continuous reads, 2 random

  logic        o_gnt0, o_gnt1, o_sel, o_rv0, o_rv1, o_err1, o_idle;
  logic [31:0] o_rd0, o_rd1;
  logic [AW-1:0] o_addr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_legal(input logic [2:0] s, input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    if (s > 3'd2) return 1'b0;
    if (s == 3'd1) return (ai % 2) == 0;
    if (s == 3'd2) return (ai % 4) == 0;
    return 1'b1;
  endfunction

  function automatic int model_pick();
    if (rq[0] && rq[1]) begin
      if (cfg_rr) return (m_last == 0) ? 1 : 0;
      return (m_wait == MAX_WAIT) ? 1 : 0;
    end
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  task automatic model_clear();
    m_last = 1;
    m_wait = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic w, input logic [2:0] s,
                         input logic [AW-1:0] a, input logic [31:0] d);
    rq[p] = 1'b1; wr[p] = w; sz[p] = s; ad[p] = a; wd[p] = d;
  endtask

  task automatic refill();
    int a;
    logic [2:0] s;
    for (int p = 0; p < 2; p++) begin
      if (mode[p] == 1 && !rq[p]) begin
        set_req(p, 1'b0, 3'd2, AW'($urandom_range(0, 15) * 4), 32'h0);
      end else if (mode[p] == 2) begin
        if (!rq[p] && $urandom_range(0, 1) == 1) begin
          s = ($urandom_range(0, 7) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
          a = int'($urandom_range(0, 63));
          if ($urandom_range(0, 3) != 0) begin
            if (s == 3'd1) a = a & ~1;
            if (s == 3'd2) a = a & ~3;
          end
          set_req(p, 1'($urandom_range(0, 1)), s, AW'(a), $urandom);
        end else if (rq[p] && $urandom_range(0, 15) == 0) begin
          rq[p] = 1'b0;
        end
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model, drive after the rising edge.
  task automatic tick();
    int          w, pend;
    bit          lg;
    logic [33:0] e, exp0, exp1;
    logic [53:0] exp_ram;
    logic [9:0]  idx;
    logic [31:0] m;
    @(negedge clk);
    w = model_pick();
    o_gnt0 = p0_gnt; o_gnt1 = p1_gnt; o_sel = ram_sel; o_addr = ram_addr;
    o_rv0 = p0_rvalid; o_rd0 = p0_rdata; o_rv1 = p1_rvalid; o_rd1 = p1_rdata;
    o_err1 = p1_err; o_idle = ram_idle;

    chk("p0_gnt", 64'(p0_gnt), 64'(w == 0));
    chk("p1_gnt", 64'(p1_gnt), 64'(w == 1));
    exp_ram = '0;
    lg = 1'b0;
    if (w >= 0) begin
      lg = model_legal(sz[w], ad[w]);
      if (lg) exp_ram = {1'b1, wr[w], sz[w], ad[w], wd[w]};
    end
    chk("ram_cmd", 64'({ram_sel, ram_write, ram_size, ram_addr, ram_wdata}), 64'(exp_ram));

    pend = exp_q.size();
    chk("ram_idle", 64'(ram_idle), 64'(!rq[0] && !rq[1] && pend == 0));
    exp0 = '0;
    exp1 = '0;
    if (pend > 0) begin
      e = exp_q.pop_front();
      if (e[32]) exp1 = {1'b1, e[33], e[31:0]};
      else       exp0 = {1'b1, e[33], e[31:0]};
    end
    chk("p0_rsp", 64'({p0_rvalid, p0_err, p0_rdata}), 64'(exp0));
    chk("p1_rsp", 64'({p1_rvalid, p1_err, p1_rdata}), 64'(exp1));

    if (w >= 0) begin
      m_last = w;
      idx = ad[w][11:2];
      if (!lg) begin
        exp_q.push_back({1'b1, 1'(w), 32'h0});
      end else if (!wr[w]) begin
        exp_q.push_back({1'b0, 1'(w), ref_mem[idx]});
      end else begin
        m = lane_mask(sz[w], ad[w][1:0]);
        ref_mem[idx] = (ref_mem[idx] & ~m) | (wd[w] & m);
      end
    end
    if (cfg_rr || !rq[1] || w == 1) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;

    @(posedge clk);
    #1;
    if (w >= 0) rq[w] = 1'b0;
    refill();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int      first_p1;
    int      n_p0;
    logic [3:0] seq;
    int      n_g;

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    end
    ram_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    cfg_rr = 1'b0;
    mode[0] = 0; mode[1] = 0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wr[p] = 1'b0; sz[p] = 3'd0; ad[p] = '0; wd[p] = '0;
    end

    // Reset: outputs must stay quiet even with a request present.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1'b0, 3'd2, 17'h00010, 32'h0);
    @(negedge clk);
    chk("rst_outs", 64'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
                         ram_sel, ram_write, ram_size, ram_addr, ram_wdata}), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rq[0] = 1'b0;
    model_clear();
    tick();
    chk("idle_after_rst", 64'(o_idle), 64'h1);

    // Single read
    set_req(0, 1'b0, 3'd2, 17'h00010, 32'h0);
    tick();
    chk("rd_gnt_sel_addr", 64'({o_gnt0, o_sel, o_addr}), 64'({1'b1, 1'b1, 17'h00010}));
    tick();
    chk("rd_data", 64'({o_rv0, o_rd0, o_rv1}), 64'({1'b1, 32'hDEAD_BEEF, 1'b0}));

    // Fixed-priority contention with starvation relief
    mode[0] = 1; mode[1] = 1;
    refill();
    first_p1 = -1;
    n_p0 = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (o_gnt1 && first_p1 < 0) first_p1 = i;
      if (o_gnt0) n_p0++;
    end
    chk("starve_cycle", 64'(first_p1), 64'd8);
    chk("p0_run", 64'(n_p0), 64'd8);

    // Round-robin alternation
    cfg_rr = 1'b1;
    seq = '0;
    n_g = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seq = {seq[2:0], o_gnt1};
      if (o_gnt0 ^ o_gnt1) n_g++;
    end
    chk("rr_seq", 64'(seq), 64'(4'b0101));
    chk("rr_grants", 64'(n_g), 64'd4);
    mode[0] = 0; mode[1] = 0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    cfg_rr = 1'b0;
    repeat (2) tick();

    // Illegal halfword write from port 1
    set_req(1, 1'b1, 3'd1, 17'h00003, 32'hCAFE_F00D);
    tick();
    chk("ill_gnt_nosel", 64'({o_gnt1, o_sel}), 64'({1'b1, 1'b0}));
    tick();
    chk("ill_rsp", 64'({o_rv1, o_err1, o_rd1}), 64'({1'b1, 1'b1, 32'h0}));

    // Back-to-back write then read
    set_req(0, 1'b1, 3'd2, 17'h00020, 32'h1122_3344);
    tick();
    chk("b2b_wr_gnt", 64'(o_gnt0), 64'h1);
    set_req(0, 1'b0, 3'd2, 17'h00020, 32'h0);
    tick();
    chk("b2b_rd_gnt", 64'(o_gnt0), 64'h1);
    tick();
    chk("b2b_rd_data", 64'({o_rv0, o_rd0}), 64'({1'b1, 32'h1122_3344}));

    // Reset in the response cycle of a read
    set_req(0, 1'b0, 3'd2, 17'h00010, 32'h0);
    tick();
    rst = 1'b1;
    set_req(0, 1'b0, 3'd2, 17'h00014, 32'h0);
    @(negedge clk);
    chk("rst_mid_rd", 64'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
                           ram_sel, ram_write, ram_size, ram_addr, ram_wdata}), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rq[0] = 1'b0;
    model_clear();
    tick();
    chk("idle_post_rst", 64'({o_idle, o_rv0}), 64'({1'b1, 1'b0}));

    // Randomized traffic
    mode[0] = 2; mode[1] = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) cfg_rr = ~cfg_rr;
      tick();
    end
    mode[0] = 0; mode[1] = 0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    repeat (2) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
